pipe_stage_buf: RTL and testbench

Parametrised pipeline-register stage that replaces the fixed IF/ID, ID/EX and EX/MEM buffers in the processor pipeline. It carries a DATA_W-bit stage bundle from one pipeline stage to the next using a valid/ready handshake. Internal storage holds DEPTH entries, so a stall in a downstream stage does not combinationally stall the upstream stage. A synchronous flush turns every in-flight entry into a bubble, for branch and hazard recovery.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_stage_buf.sv | 77 +++++++
 tb/tb_pipe_stage_buf.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the processor pipeline registers: stage bundle widths,
// control-field bit positions and the bubble value each stage register presents.
package pipe_pkg;

  localparam int IFID_W  = 32;
  localparam int IDEX_W  = 40;
  localparam int EXMEM_W = 70;

  // ID/EX bundle: control bits at the top, destination register below them
  localparam int IDEX_WB_REG_WRITE = 39;
  localparam int IDEX_WB_MEM2REG   = 38;
  localparam int IDEX_MW           = 37;
  localparam int IDEX_MR           = 36;
  localparam int IDEX_ALU_SRC      = 35;
  localparam int IDEX_ALUOP_HI     = 34;
  localparam int IDEX_ALUOP_LO     = 33;
  localparam int IDEX_RD_HI        = 32;
  localparam int IDEX_RD_LO        = 28;

  // EX/MEM bundle: WB and MEM control on top, then rd, then ALU result and store data
  localparam int EXMEM_WB_REG_WRITE = 69;
  localparam int EXMEM_WB_MEM2REG   = 68;
  localparam int EXMEM_MW           = 67;
  localparam int EXMEM_MR           = 66;
  localparam int EXMEM_RD_HI        = 65;
  localparam int EXMEM_RD_LO        = 61;

  // IF/ID carries a raw instruction, so its bubble is the canonical no-op encoding;
  // later stages only need every control bit cleared.
  localparam logic [IFID_W-1:0]  IFID_NOP  = 32'h0000_0013;
  localparam logic [IDEX_W-1:0]  IDEX_NOP  = '0;
  localparam logic [EXMEM_W-1:0] EXMEM_NOP = '0;

endpackage

// File: rtl/pipe_stage_buf.sv
// Pipeline register stage with DEPTH-entry circular storage, valid/ready handshake
// on both sides and a synchronous flush that turns everything in flight into bubbles.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = IDEX_W,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  if (DEPTH < 1 || DATA_W < 1) begin : g_param_check
    $error("pipe_stage_buf: DEPTH and DATA_W must both be at least 1");
  end

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // in_ready depends only on registered occupancy, keeping out_ready off the upstream path
  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : NOP_VALUE;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_ONE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: out_data is masked to NOP_VALUE whenever count is zero
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (DEPTH 2, 3, 1) checked every cycle against
// a FIFO-occupancy model, plus directed scenarios with literal expectations.
module tb_pipe_stage_buf;

  localparam int          DEPTHS[3] = '{2, 3, 1};
  localparam logic [39:0] NOP1      = 40'hC0_FFEE_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv[3], ord[3], fl[3], ov[3], ir[3];
  logic [39:0] id[3], od[3];
  logic [1:0]  cnt0, cnt1;
  logic [0:0]  cnt2;

  int total = 0;
  int bad   = 0;

  // model: contents of each stage as a plain ordered list, plus a log of delivered bundles
  logic [39:0] mdl[3][8];
  int          msz[3] = '{0, 0, 0};
  logic [39:0] dlog[3][64];
  int          dn[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(40), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .flush(fl[0]), .out_valid(ov[0]), .out_ready(ord[0]), .out_data(od[0]), .count(cnt0));

  pipe_stage_buf #(.DATA_W(40), .DEPTH(3), .NOP_VALUE(NOP1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .flush(fl[1]), .out_valid(ov[1]), .out_ready(ord[1]), .out_data(od[1]), .count(cnt1));

  pipe_stage_buf #(.DATA_W(40), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .flush(fl[2]), .out_valid(ov[2]), .out_ready(ord[2]), .out_data(od[2]), .count(cnt2));

  function automatic logic [39:0] nop_of(input int i);
    return (i == 1) ? NOP1 : 40'h0;
  endfunction

  function automatic logic [39:0] cnt_of(input int i);
    case (i)
      0:       return 40'(cnt0);
      1:       return 40'(cnt1);
      default: return 40'(cnt2);
    endcase
  endfunction

  function automatic bit m_push(input int i);
    return iv[i] && (msz[i] < DEPTHS[i]);
  endfunction

  function automatic bit m_pop(input int i);
    return ord[i] && (msz[i] > 0);
  endfunction

  task automatic chk(input string nm, input int i, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) msz[i] <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_pop(i) && dn[i] < 64) begin
          dlog[i][dn[i]] <= mdl[i][0];
          dn[i]          <= dn[i] + 1;
        end
        if (fl[i]) begin
          msz[i] <= 0;
        end else begin
          if (m_pop(i))
            for (int k = 0; k < 7; k++) mdl[i][k] <= mdl[i][k+1];
          if (m_push(i)) mdl[i][msz[i] - (m_pop(i) ? 1 : 0)] <= id[i];
          msz[i] <= msz[i] + (m_push(i) ? 1 : 0) - (m_pop(i) ? 1 : 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("out_valid", i, 40'(ov[i]), 40'(msz[i] != 0));
      chk("in_ready", i, 40'(ir[i]), 40'(msz[i] < DEPTHS[i]));
      chk("count", i, cnt_of(i), 40'(msz[i]));
      chk("out_data", i, od[i], (msz[i] != 0) ? mdl[i][0] : nop_of(i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, guard, hits, maxc, nacc;
    bit acc;
    logic [39:0] nxt;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ord[i] = 1'b0; fl[i] = 1'b0; id[i] = '0;
    end

    // reset held while a bundle is offered
    iv[0] = 1'b1; id[0] = 40'h12_3456_789A;
    repeat (2) @(negedge clk);
    #1;
    chk("t1_rst_valid", 0, 40'(ov[0]), 40'h0);
    chk("t1_rst_data", 0, od[0], 40'h0);
    chk("t1_rst_count", 0, 40'(cnt0), 40'h0);
    chk("t1_rst_ready", 0, 40'(ir[0]), 40'h1);
    chk("t1_rst_nop1", 1, od[1], NOP1);
    rst_n = 1'b1;
    tick();
    chk("t1_first_push_cnt", 0, 40'(cnt0), 40'h1);
    chk("t1_first_push_data", 0, od[0], 40'h12_3456_789A);
    iv[0] = 1'b0; ord[0] = 1'b1;
    tick();

    // streaming through DEPTH=2
    s = dn[0];
    for (int v = 1; v <= 8; v++) begin
      iv[0] = 1'b1; id[0] = 40'(v);
      tick();
      chk("t2_stream_data", 0, od[0], 40'(v));
      chk("t2_stream_cnt", 0, 40'(cnt0), 40'h1);
    end
    iv[0] = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) chk("t2_order", 0, dlog[0][s+k], 40'(k + 1));

    // backpressure, full, held offer
    s = dn[0];
    ord[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 40'hA1; tick();
    id[0] = 40'hA2; tick();
    chk("t3_full_cnt", 0, 40'(cnt0), 40'h2);
    chk("t3_full_ready", 0, 40'(ir[0]), 40'h0);
    id[0] = 40'hA3; tick(); tick();
    chk("t3_held_cnt", 0, 40'(cnt0), 40'h2);
    chk("t3_held_head", 0, od[0], 40'hA1);
    ord[0] = 1'b1;
    tick();
    chk("t3_no_push_when_full", 0, 40'(cnt0), 40'h1);
    tick();
    chk("t3_a3_taken", 0, od[0], 40'hA3);
    iv[0] = 1'b0;
    tick();
    chk("t3_ndeliv", 0, 40'(dn[0] - s), 40'd3);
    chk("t3_o1", 0, dlog[0][s], 40'hA1);
    chk("t3_o2", 0, dlog[0][s+1], 40'hA2);
    chk("t3_o3", 0, dlog[0][s+2], 40'hA3);

    // flush with full stage, then flush with a push that would have been accepted
    s = dn[0];
    ord[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 40'hB1; tick();
    id[0] = 40'hB2; tick();
    chk("t4_pre_cnt", 0, 40'(cnt0), 40'h2);
    id[0] = 40'hB3; fl[0] = 1'b1; tick();
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("t4_flush_cnt", 0, 40'(cnt0), 40'h0);
    chk("t4_flush_valid", 0, 40'(ov[0]), 40'h0);
    chk("t4_flush_data", 0, od[0], 40'h0);
    iv[0] = 1'b1; id[0] = 40'hC1; tick();
    id[0] = 40'hC2; ord[0] = 1'b1; fl[0] = 1'b1;
    chk("t4_ready_in_flush", 0, 40'(ir[0]), 40'h1);
    tick();
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("t4_flush2_cnt", 0, 40'(cnt0), 40'h0);
    iv[0] = 1'b1; id[0] = 40'hD1; tick();
    iv[0] = 1'b0;
    chk("t4_after_flush_data", 0, od[0], 40'hD1);
    tick();
    hits = 0;
    for (int k = s; k < dn[0]; k++)
      if (dlog[0][k] == 40'hB3 || dlog[0][k] == 40'hC2) hits++;
    chk("t4_discarded_never_out", 0, 40'(hits), 40'h0);
    chk("t4_c1_consumed", 0, dlog[0][s], 40'hC1);

    // DEPTH=3 with random out_ready across pointer wrap
    s = dn[1]; maxc = 0;
    for (int v = 1; v <= 20; v++) begin
      iv[1] = 1'b1; id[1] = 40'(v); guard = 0;
      do begin
        acc = ir[1];
        ord[1] = 1'($urandom_range(0, 1));
        tick();
        if (int'(cnt1) > maxc) maxc = int'(cnt1);
        guard++;
      end while (!acc && guard < 50);
      if (!acc) chk("t5_accept_timeout", 1, 40'h0, 40'h1);
    end
    iv[1] = 1'b0; ord[1] = 1'b1; guard = 0;
    while (cnt1 != 0 && guard < 10) begin tick(); guard++; end
    chk("t5_drained", 1, 40'(cnt1), 40'h0);
    chk("t5_max_cnt", 1, 40'(maxc <= 3), 40'h1);
    chk("t5_ndeliv", 1, 40'(dn[1] - s), 40'd20);
    for (int k = 0; k < 20; k++) chk("t5_order", 1, dlog[1][s+k], 40'(k + 1));
    chk("t5_empty_nop", 1, od[1], NOP1);

    // DEPTH=1 alternating handshake
    s = dn[2]; nacc = 0; nxt = 40'h60;
    ord[2] = 1'b1; iv[2] = 1'b1; id[2] = nxt;
    for (int k = 0; k < 8; k++) begin
      acc = ir[2];
      tick();
      if (acc) begin nxt = nxt + 40'h1; id[2] = nxt; nacc++; end
      chk("t6_ready_toggle", 2, 40'(ir[2]), 40'(k % 2));
    end
    iv[2] = 1'b0;
    chk("t6_naccepted", 2, 40'(nacc), 40'd4);
    chk("t6_ndeliv", 2, 40'(dn[2] - s), 40'd4);
    for (int k = 0; k < 4; k++) chk("t6_order", 2, dlog[2][s+k], 40'h60 + 40'(k));

    // asynchronous reset in the middle of a cycle with entries held
    ord[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 40'hE1; tick();
    id[0] = 40'hE2; tick();
    chk("t7_pre_cnt", 0, 40'(cnt0), 40'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_cnt", 0, 40'(cnt0), 40'h0);
    chk("t7_async_valid", 0, 40'(ov[0]), 40'h0);
    chk("t7_async_data", 0, od[0], 40'h0);
    chk("t7_async_ready", 0, 40'(ir[0]), 40'h1);
    @(negedge clk);
    #1 rst_n = 1'b1; id[0] = 40'hE3;
    tick();
    chk("t7_post_rst_push", 0, od[0], 40'hE3);
    chk("t7_post_rst_cnt", 0, 40'(cnt0), 40'h1);
    iv[0] = 1'b0; ord[0] = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
